// File: rtl/dmem_arbiter.sv
// Round-robin 2-port arbiter/sequencer for a single-port word memory; handshake -> ACCESS -> RESP (response 2 cycles after handshake cycle).
// Backpressure: req_ready only in IDLE, one transaction per 3 cycles; responses are single-cycle pulses with no backpressure.
module dmem_arbiter #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        port_q, we_q, err_q, last_grant;
  logic [31:0] addr_q, wdata_q, rsp_rdata_q;
  logic        winner, hs;
  logic [31:0] win_addr, win_wdata;

  // Contention goes to the port that did not win last time.
  always_comb begin
    winner    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    win_addr  = winner ? req_addr1 : req_addr0;
    win_wdata = winner ? req_wdata1 : req_wdata0;
    hs        = (state == IDLE) && (req_valid != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid != 2'b00) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    rsp_err      = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE:    if (hs && !rst) req_ready[winner] = 1'b1;
      ACCESS:  mem_write_en = we_q & ~err_q;
      RESP: begin
        rsp_valid[port_q] = 1'b1;
        rsp_err           = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      last_grant  <= 1'b1;
    end else begin
      if (hs) begin
        port_q     <= winner;
        we_q       <= req_we[winner];
        addr_q     <= win_addr;
        wdata_q    <= win_wdata;
        err_q      <= (win_addr[1:0] != 2'b00) || (win_addr >= ADDR_LIMIT);
        last_grant <= winner;
      end
      // Stores and rejected accesses answer with zero data.
      if (state == ACCESS)
        rsp_rdata_q <= (we_q | err_q) ? 32'd0 : mem_read_data;
    end
  end

  assign rsp_rdata      = rsp_rdata_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

endmodule
